// File: rtl/ahb_bus_arbiter_if.sv
// Request/transfer inputs and grant/owner outputs shared by the masters and the arbiter.
// The arbiter uses the slave modport; the master-side logic (or a bench) uses master.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS  = 4,
  parameter int MIDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int HTRANS_WIDTH = 2,
  parameter int HBURST_WIDTH = 3
);
  logic [NUM_MASTERS-1:0]  hbusreq;
  logic [NUM_MASTERS-1:0]  hlock;
  logic [HTRANS_WIDTH-1:0] Htrans;
  logic [HBURST_WIDTH-1:0] Hburst;
  logic                    Hready;
  logic [NUM_MASTERS-1:0]  hgrant;
  logic [MIDX_W-1:0]       hmaster;
  logic [MIDX_W-1:0]       hmaster_data;
  logic                    Hmastlock;

  modport slave (
    input  hbusreq, hlock, Htrans, Hburst, Hready,
    output hgrant, hmaster, hmaster_data, Hmastlock
  );

  modport master (
    output hbusreq, hlock, Htrans, Hburst, Hready,
    input  hgrant, hmaster, hmaster_data, Hmastlock
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with fixed-burst and locked-sequence protection, parking on master 0.
// Htrans/Hburst are those of the granted master, i.e. the address offered for acceptance at the edge.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS  = 4,
  parameter int MIDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int HTRANS_WIDTH = 2,
  parameter int HBURST_WIDTH = 3
) (
  input logic              hclk,
  input logic              hreset,
  ahb_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ST_PARK, ST_OWNED, ST_BURST, ST_LOCKED} state_t;

  localparam logic [HTRANS_WIDTH-1:0] TR_IDLE   = HTRANS_WIDTH'(0);
  localparam logic [HTRANS_WIDTH-1:0] TR_NONSEQ = HTRANS_WIDTH'(2);
  localparam logic [HTRANS_WIDTH-1:0] TR_SEQ    = HTRANS_WIDTH'(3);

  state_t                 r_state;
  logic [MIDX_W-1:0]      r_grant;
  logic [NUM_MASTERS-1:0] r_hgrant;
  logic [MIDX_W-1:0]      r_rr_ptr;
  logic [MIDX_W-1:0]      r_hmaster;
  logic [MIDX_W-1:0]      r_hmaster_data;
  logic                   r_mastlock;
  logic [3:0]             r_count;

  logic                   w_is_idle;
  logic                   w_is_nonseq;
  logic                   w_is_seq;
  logic                   w_fixed;
  logic [3:0]             w_burst_last;
  logic [3:0]             w_count_next;
  logic                   w_lock_next;
  logic                   w_rr_found;
  logic [MIDX_W-1:0]      w_rr_idx;

  assign w_is_idle   = (bus.Htrans == TR_IDLE);
  assign w_is_nonseq = (bus.Htrans == TR_NONSEQ);
  assign w_is_seq    = (bus.Htrans == TR_SEQ);

  // Remaining beats after the first one; INCR has no defined length so it never freezes the grant.
  always_comb begin
    w_fixed      = 1'b1;
    w_burst_last = 4'd0;
    case (int'(bus.Hburst))
      0:       w_burst_last = 4'd0;
      2, 3:    w_burst_last = 4'd3;
      4, 5:    w_burst_last = 4'd7;
      6, 7:    w_burst_last = 4'd15;
      default: w_fixed      = 1'b0;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    if (r_state == ST_BURST && (w_is_idle || w_is_nonseq)) begin
      w_count_next = 4'd0;
    end else if (w_is_nonseq) begin
      w_count_next = w_fixed ? w_burst_last : 4'd0;
    end else if (w_is_idle) begin
      w_count_next = 4'd0;
    end else if (w_is_seq && r_count != 4'd0) begin
      w_count_next = r_count - 4'd1;
    end
  end

  // A lock holder keeps the bus through BUSY/SEQ even after dropping hlock.
  always_comb begin
    if (r_state == ST_LOCKED) begin
      w_lock_next = bus.hlock[r_grant] || !(w_is_idle || w_is_nonseq);
    end else begin
      w_lock_next = bus.hlock[r_grant];
    end
  end

  always_comb begin : rr_search
    logic [MIDX_W-1:0] cand;
    cand       = r_rr_ptr;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int off = 0; off < NUM_MASTERS; off++) begin
      cand = (cand == MIDX_W'(NUM_MASTERS - 1)) ? '0 : cand + 1'b1;
      if (!w_rr_found && bus.hbusreq[cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = cand;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state        <= ST_PARK;
      r_grant        <= '0;
      r_hgrant       <= NUM_MASTERS'(1);
      r_rr_ptr       <= '0;
      r_hmaster      <= '0;
      r_hmaster_data <= '0;
      r_mastlock     <= 1'b0;
      r_count        <= 4'd0;
    end else if (bus.Hready) begin
      r_hmaster      <= r_grant;
      r_hmaster_data <= r_hmaster;
      r_count        <= w_count_next;
      r_mastlock     <= w_lock_next;
      if (w_lock_next) begin
        r_state <= ST_LOCKED;
      end else if (w_count_next != 4'd0) begin
        r_state <= ST_BURST;
      end else if (w_rr_found) begin
        r_state  <= ST_OWNED;
        r_grant  <= w_rr_idx;
        r_hgrant <= NUM_MASTERS'(1) << w_rr_idx;
        r_rr_ptr <= w_rr_idx;
      end else begin
        r_state  <= ST_PARK;
        r_grant  <= '0;
        r_hgrant <= NUM_MASTERS'(1);
      end
    end
  end

  assign bus.hgrant       = r_hgrant;
  assign bus.hmaster      = r_hmaster;
  assign bus.hmaster_data = r_hmaster_data;
  assign bus.Hmastlock    = r_mastlock;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a rule-level model.
`timescale 1ns/1ps
module tb_ahb_bus_arbiter;
  localparam int N  = 4;
  localparam int MW = 2;
  localparam int IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3;

  logic hclk = 1'b0;
  logic hreset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_on = 1'b0;

  ahb_bus_arbiter_if #(.NUM_MASTERS(N), .MIDX_W(MW), .HTRANS_WIDTH(2), .HBURST_WIDTH(3)) bus ();

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MIDX_W(MW), .HTRANS_WIDTH(2), .HBURST_WIDTH(3)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  // Model: who holds the grant, the round-robin pointer, beats still owed, and lock ownership.
  int m_grant = 0, m_rr = 0, m_hm = 0, m_hd = 0, m_left = 0;
  bit m_lock = 1'b0, m_mlock = 1'b0;

  function automatic int beats_of(input int hb);
    case (hb)
      0:       return 1;
      1:       return 0;
      2, 3:    return 4;
      4, 5:    return 8;
      default: return 16;
    endcase
  endfunction

  task automatic model_edge();
    int tr, hb, w;
    bit in_burst;
    if (hreset) begin
      m_grant = 0; m_rr = 0; m_hm = 0; m_hd = 0; m_left = 0; m_lock = 0; m_mlock = 0;
      return;
    end
    if (bus.Hready !== 1'b1) return;
    tr = int'(bus.Htrans);
    hb = int'(bus.Hburst);
    in_burst = !m_lock && (m_left > 0);
    if (tr == IDLE || (tr == NONSEQ && in_burst)) m_left = 0;
    else if (tr == NONSEQ) m_left = (beats_of(hb) > 1) ? beats_of(hb) - 1 : 0;
    else if (tr == SEQ && m_left > 0) m_left = m_left - 1;
    if (m_lock) m_lock = bus.hlock[m_grant] || tr == BUSY || tr == SEQ;
    else        m_lock = bus.hlock[m_grant];
    m_hd = m_hm;
    m_hm = m_grant;
    m_mlock = m_lock;
    if (!m_lock && m_left == 0) begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && bus.hbusreq[(m_rr + k) % N]) w = (m_rr + k) % N;
      if (w >= 0) begin m_grant = w; m_rr = w; end
      else m_grant = 0;
    end
  endtask

  initial forever begin
    @(posedge hclk);
    model_edge();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge hclk);
    if (chk_on) begin
      chk("hgrant", 32'(bus.hgrant), 32'(1) << m_grant);
      chk("hmaster", 32'(bus.hmaster), m_hm);
      chk("hmaster_data", 32'(bus.hmaster_data), m_hd);
      chk("Hmastlock", 32'(bus.Hmastlock), 32'(m_mlock));
    end
  end

  task automatic cyc(input logic [3:0] req, input logic [3:0] lk, input int tr, input int hb,
                     input bit rdy);
    bus.hbusreq = req;
    bus.hlock   = lk;
    bus.Htrans  = 2'(tr);
    bus.Hburst  = 3'(hb);
    bus.Hready  = rdy;
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    cyc(4'b0000, 4'b0000, IDLE, 0, 1'b1);
    hreset = 1'b0;
  endtask

  initial begin
    int exp_hm, prev_hm, tr, hb;
    logic [3:0] rq, lk;
    bit rdy;
    bus.hbusreq = '0; bus.hlock = '0; bus.Htrans = '0; bus.Hburst = '0; bus.Hready = 1'b1;
    #2;
    do_reset();
    chk_on = 1'b1;

    // Idle after reset: parked on master 0.
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0000, 4'b0000, IDLE, 0, 1'b1);
      chk("park_grant", 32'(bus.hgrant), 32'b0001);
      chk("park_hmaster", 32'(bus.hmaster), 0);
      chk("park_lock", 32'(bus.Hmastlock), 0);
    end

    // Masters 1 and 2 alternate on SINGLE transfers.
    do_reset();
    prev_hm = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc(4'b0110, 4'b0000, NONSEQ, 0, 1'b1);
      exp_hm = (k == 1) ? 0 : ((k % 2 == 0) ? 1 : 2);
      chk("rr_grant", 32'(bus.hgrant), (k % 2 == 1) ? 32'b0010 : 32'b0100);
      chk("rr_hmaster", 32'(bus.hmaster), exp_hm);
      chk("rr_hdata", 32'(bus.hmaster_data), prev_hm);
      chk("rr_model_pin", m_grant, (k % 2 == 1) ? 1 : 2);
      prev_hm = exp_hm;
    end

    // INCR8 from master 2 with a two-cycle stall on beat 3, master 1 waiting.
    do_reset();
    cyc(4'b0100, 4'b0000, IDLE, 0, 1'b1);
    chk("b8_start", 32'(bus.hgrant), 32'b0100);
    cyc(4'b0110, 4'b0000, NONSEQ, 5, 1'b1);
    chk("b8_beat1", 32'(bus.hgrant), 32'b0100);
    cyc(4'b0110, 4'b0000, SEQ, 5, 1'b1);
    chk("b8_beat2", 32'(bus.hgrant), 32'b0100);
    for (int s = 0; s < 2; s++) begin
      cyc(4'b0110, 4'b0000, SEQ, 5, 1'b0);
      chk("b8_stall", 32'(bus.hgrant), 32'b0100);
    end
    for (int b = 3; b <= 7; b++) begin
      cyc(4'b0110, 4'b0000, SEQ, 5, 1'b1);
      chk("b8_beat", 32'(bus.hgrant), 32'b0100);
    end
    cyc(4'b0110, 4'b0000, SEQ, 5, 1'b1);
    chk("b8_handover", 32'(bus.hgrant), 32'b0010);

    // INCR4 from master 3 with one BUSY; five accepted phases before handover.
    do_reset();
    cyc(4'b1000, 4'b0000, IDLE, 0, 1'b1);
    chk("b4_start", 32'(bus.hgrant), 32'b1000);
    cyc(4'b1001, 4'b0000, NONSEQ, 3, 1'b1);
    chk("b4_p1", 32'(bus.hgrant), 32'b1000);
    cyc(4'b1001, 4'b0000, SEQ, 3, 1'b1);
    chk("b4_p2", 32'(bus.hgrant), 32'b1000);
    cyc(4'b1001, 4'b0000, SEQ, 3, 1'b1);
    chk("b4_p3", 32'(bus.hgrant), 32'b1000);
    cyc(4'b1001, 4'b0000, BUSY, 3, 1'b1);
    chk("b4_busy", 32'(bus.hgrant), 32'b1000);
    cyc(4'b1001, 4'b0000, SEQ, 3, 1'b1);
    chk("b4_handover", 32'(bus.hgrant), 32'b0001);

    // Locked SINGLE sequence from master 1 while master 0 requests.
    do_reset();
    cyc(4'b0011, 4'b0010, IDLE, 0, 1'b1);
    chk("lk_grant", 32'(bus.hgrant), 32'b0010);
    chk("lk_pre", 32'(bus.Hmastlock), 0);
    for (int p = 0; p < 3; p++) begin
      cyc(4'b0011, 4'b0010, NONSEQ, 0, 1'b1);
      chk("lk_mastlock", 32'(bus.Hmastlock), 1);
      chk("lk_hold", 32'(bus.hgrant), 32'b0010);
      chk("lk_hmaster", 32'(bus.hmaster), 1);
    end
    cyc(4'b0011, 4'b0000, IDLE, 0, 1'b1);
    chk("lk_release", 32'(bus.Hmastlock), 0);
    chk("lk_handover", 32'(bus.hgrant), 32'b0001);

    // Reset during beat 5 of INCR16 from master 2.
    do_reset();
    cyc(4'b0100, 4'b0000, IDLE, 0, 1'b1);
    cyc(4'b0100, 4'b0000, NONSEQ, 7, 1'b1);
    for (int b = 0; b < 3; b++) cyc(4'b0100, 4'b0000, SEQ, 7, 1'b1);
    chk("b16_held", 32'(bus.hgrant), 32'b0100);
    chk("b16_hmaster", 32'(bus.hmaster), 2);
    hreset = 1'b1;
    cyc(4'b0100, 4'b0000, SEQ, 7, 1'b1);
    hreset = 1'b0;
    chk("rst_grant", 32'(bus.hgrant), 32'b0001);
    chk("rst_hmaster", 32'(bus.hmaster), 0);
    chk("rst_hdata", 32'(bus.hmaster_data), 0);
    chk("rst_lock", 32'(bus.Hmastlock), 0);
    cyc(4'b0010, 4'b0000, BUSY, 7, 1'b1);
    chk("rst_counter_clear", 32'(bus.hgrant), 32'b0010);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      rq  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rq = 4'b0000;
      lk  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rdy = ($urandom_range(0, 3) != 0);
      hb  = $urandom_range(0, 7);
      if (m_left > 0) begin
        case ($urandom_range(0, 19))
          0, 1, 2: tr = BUSY;
          3:       tr = IDLE;
          4:       tr = NONSEQ;
          default: tr = SEQ;
        endcase
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: tr = NONSEQ;
          5:             tr = SEQ;
          default:       tr = IDLE;
        endcase
      end
      hreset = ($urandom_range(0, 299) == 0);
      cyc(rq, lk, tr, hb, rdy);
      hreset = 1'b0;
    end

    @(negedge hclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
